// File: rtl/line_buffer_addr_sequencer.sv
// Address sequencer for a rotating set of line buffers: a write pointer fills lines in
// WR_STRIDE-pixel beats while a read FSM sweeps a WINDOW-line neighbourhood per pass.
module line_buffer_addr_sequencer #(
    parameter int DEPTH     = 512,
    parameter int WR_STRIDE = 8,
    parameter int NUM_LINES = 4,
    parameter int WINDOW    = 3,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(NUM_LINES),
    localparam int CW = $clog2(NUM_LINES + 1)
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          softClear,
    input  logic          wrValid,
    output logic          wrReady,
    output logic          wrEn,
    output logic [AW-1:0] writeAddress,
    output logic [LW-1:0] writeLine,
    input  logic          rdEn,
    input  logic          rdReady,
    output logic          rdValid,
    output logic [AW-1:0] readAddress,
    output logic [LW-1:0] readLineBase,
    output logic          lineDone,
    output logic [CW-1:0] fullLines
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } readState_t;

    localparam logic [AW-1:0] WR_LAST      = AW'(DEPTH - WR_STRIDE);
    localparam logic [AW-1:0] RD_LAST      = AW'(DEPTH - 1);
    localparam logic [AW-1:0] WR_STEP      = AW'(WR_STRIDE);
    localparam logic [AW-1:0] ADDR_ONE     = AW'(1);
    localparam logic [LW-1:0] LAST_LINE    = LW'(NUM_LINES - 1);
    localparam logic [LW-1:0] LINE_ONE     = LW'(1);
    localparam logic [CW-1:0] FULL_COUNT   = CW'(NUM_LINES);
    localparam logic [CW-1:0] WINDOW_COUNT = CW'(WINDOW);
    localparam logic [CW-1:0] COUNT_ONE    = CW'(1);

    readState_t state_r;
    logic       wrAccept_s;
    logic       lineComplete_s;
    logic       rdAccept_s;
    logic       lineRetire_s;

    // NUM_LINES need not be a power of two, so the line index wraps explicitly
    function automatic logic [LW-1:0] nextLine(input logic [LW-1:0] line);
        logic [LW-1:0] result;
        if (line == LAST_LINE) begin
            result = {LW{1'b0}};
        end else begin
            result = line + LINE_ONE;
        end
        return result;
    endfunction

    // Handshake decode for the write and read sides
    always_comb begin
        wrReady        = (fullLines != FULL_COUNT);
        wrAccept_s     = wrValid && wrReady;
        lineComplete_s = wrAccept_s && (writeAddress == WR_LAST);
        rdAccept_s     = (state_r == READ) && rdReady;
        lineRetire_s   = rdAccept_s && (readAddress == RD_LAST);
    end

    // Write pointer: beat address within the line and the line being filled
    always_ff @(posedge clk) begin
        if (!resetN || softClear) begin
            wrEn         <= 1'b0;
            writeAddress <= {AW{1'b0}};
            writeLine    <= {LW{1'b0}};
        end else begin
            wrEn <= wrAccept_s;
            if (lineComplete_s) begin
                writeAddress <= {AW{1'b0}};
                writeLine    <= nextLine(writeLine);
            end else if (wrAccept_s) begin
                writeAddress <= writeAddress + WR_STEP;
            end else begin
                writeAddress <= writeAddress;
            end
        end
    end

    // Occupancy: completed lines not yet retired by a read pass
    always_ff @(posedge clk) begin
        if (!resetN || softClear) begin
            fullLines <= {CW{1'b0}};
        end else if (lineComplete_s && !lineRetire_s) begin
            fullLines <= fullLines + COUNT_ONE;
        end else if (lineRetire_s && !lineComplete_s) begin
            fullLines <= fullLines - COUNT_ONE;
        end else begin
            fullLines <= fullLines;
        end
    end

    // Read FSM: one full sweep of the window per pass, IDLE bubble between passes
    always_ff @(posedge clk) begin
        if (!resetN || softClear) begin
            state_r      <= IDLE;
            rdValid      <= 1'b0;
            readAddress  <= {AW{1'b0}};
            readLineBase <= {LW{1'b0}};
            lineDone     <= 1'b0;
        end else begin
            lineDone <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (rdEn && (fullLines >= WINDOW_COUNT)) begin
                        state_r <= READ;
                        rdValid <= 1'b1;
                    end else begin
                        rdValid <= 1'b0;
                    end
                end
                READ: begin
                    if (lineRetire_s) begin
                        readAddress  <= {AW{1'b0}};
                        readLineBase <= nextLine(readLineBase);
                        lineDone     <= 1'b1;
                        rdValid      <= 1'b0;
                        state_r      <= IDLE;
                    end else if (rdAccept_s) begin
                        readAddress <= readAddress + ADDR_ONE;
                    end else begin
                        readAddress <= readAddress;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    rdValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_buffer_addr_sequencer.sv
// Scoreboard bench: a count-based reference model predicts every cycle's outputs and each
// write/read transaction; a negedge monitor pops and compares against the DUT.
module tb_line_buffer_addr_sequencer;

    localparam int DEPTH     = 512;
    localparam int WR_STRIDE = 8;
    localparam int NUM_LINES = 4;
    localparam int WINDOW    = 3;
    localparam int AW        = $clog2(DEPTH);
    localparam int LW        = $clog2(NUM_LINES);
    localparam int CW        = $clog2(NUM_LINES + 1);
    localparam int BPL       = DEPTH / WR_STRIDE;

    logic          clk = 1'b0;
    logic          resetN, softClear, wrValid, rdEn, rdReady;
    logic          wrReady, wrEn, rdValid, lineDone;
    logic [AW-1:0] writeAddress, readAddress;
    logic [LW-1:0] writeLine, readLineBase;
    logic [CW-1:0] fullLines;

    line_buffer_addr_sequencer #(
        .DEPTH(DEPTH), .WR_STRIDE(WR_STRIDE), .NUM_LINES(NUM_LINES), .WINDOW(WINDOW)
    ) dut (
        .clk(clk), .resetN(resetN), .softClear(softClear),
        .wrValid(wrValid), .wrReady(wrReady), .wrEn(wrEn),
        .writeAddress(writeAddress), .writeLine(writeLine),
        .rdEn(rdEn), .rdReady(rdReady), .rdValid(rdValid),
        .readAddress(readAddress), .readLineBase(readLineBase),
        .lineDone(lineDone), .fullLines(fullLines)
    );

    always #5 clk = ~clk;

    typedef struct {
        int wa; int wl; int ra; int rb; int full;
        bit wrReady; bit rdValid; bit lineDone; bit wrEn;
    } stat_t;
    typedef struct { int addr; int line; } tx_t;

    stat_t statQ[$];
    tx_t   wrQ[$];
    tx_t   rdQ[$];
    int    compared   = 0;
    int    mismatched = 0;

    // Reference model: totals since the last clear, everything else derived arithmetically
    int beats, passes, full, pix;
    bit rdActive, doneFlag, wrEnFlag;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelClear();
        beats = 0; passes = 0; full = 0; pix = 0;
        rdActive = 1'b0; doneFlag = 1'b0; wrEnFlag = 1'b0;
    endtask

    task automatic cycle(input bit rn, input bit sc, input bit wv, input bit re, input bit rr);
        stat_t s;
        tx_t   t;
        bit    acc, comp, ret;
        s.wa = (beats % BPL) * WR_STRIDE;
        s.wl = (beats / BPL) % NUM_LINES;
        s.ra = pix;
        s.rb = passes % NUM_LINES;
        s.full = full;
        s.wrReady = (full != NUM_LINES);
        s.rdValid = rdActive;
        s.lineDone = doneFlag;
        s.wrEn = wrEnFlag;
        statQ.push_back(s);
        resetN = rn; softClear = sc; wrValid = wv; rdEn = re; rdReady = rr;
        if (rdActive && rr) begin
            t.addr = pix;
            t.line = passes % NUM_LINES;
            rdQ.push_back(t);
        end
        if (!rn || sc) begin
            modelClear();
        end else begin
            acc  = wv && (full != NUM_LINES);
            comp = acc && ((beats % BPL) == BPL - 1);
            ret  = rdActive && rr && (pix == DEPTH - 1);
            if (rdActive) begin
                if (rr) begin
                    if (pix == DEPTH - 1) begin
                        pix = 0;
                        rdActive = 1'b0;
                    end else begin
                        pix++;
                    end
                end
            end else if (re && full >= WINDOW) begin
                rdActive = 1'b1;
            end
            beats    = beats + int'(acc);
            full     = full + int'(comp) - int'(ret);
            passes   = passes + int'(ret);
            doneFlag = ret;
            wrEnFlag = acc;
            if (acc) begin
                t.addr = (beats % BPL) * WR_STRIDE;
                t.line = (beats / BPL) % NUM_LINES;
                wrQ.push_back(t);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle status plus transaction checks on wrEn and read handshakes
    initial begin
        stat_t s;
        tx_t   t;
        forever begin
            @(negedge clk);
            if (statQ.size() > 0) begin
                s = statQ.pop_front();
                check("wrReady", int'(wrReady), int'(s.wrReady));
                check("wrEn", int'(wrEn), int'(s.wrEn));
                check("writeAddress", int'(writeAddress), s.wa);
                check("writeLine", int'(writeLine), s.wl);
                check("rdValid", int'(rdValid), int'(s.rdValid));
                check("readAddress", int'(readAddress), s.ra);
                check("readLineBase", int'(readLineBase), s.rb);
                check("lineDone", int'(lineDone), int'(s.lineDone));
                check("fullLines", int'(fullLines), s.full);
            end
            if (wrEn) begin
                if (wrQ.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    t = wrQ.pop_front();
                    check("wr_tx_addr", int'(writeAddress), t.addr);
                    check("wr_tx_line", int'(writeLine), t.line);
                end
            end
            if (rdValid && rdReady) begin
                if (rdQ.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    t = rdQ.pop_front();
                    check("rd_tx_addr", int'(readAddress), t.addr);
                    check("rd_tx_base", int'(readLineBase), t.line);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic
    initial begin
        int pw, pr;
        resetN = 1'b0; softClear = 1'b0; wrValid = 1'b0; rdEn = 1'b0; rdReady = 1'b0;
        modelClear();
        @(posedge clk);
        #1;
        repeat (2) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (BPL) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (2 * BPL) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (DEPTH + 4) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

        repeat (2 * BPL + 12) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2 * DEPTH) cycle(1'b1, 1'b0, 1'b1, 1'b1, $urandom_range(0, 3) != 0);

        // Last write beat of a line lands on the same edge as the last read accept
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4 * BPL - 1) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH + 4; i++)
            cycle(1'b1, 1'b0, rdActive && (pix == DEPTH - 1), 1'b1, 1'b1);

        // Soft clear in the middle of a pass
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3 * BPL) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 600 && !(rdActive && pix == 200); i++)
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        if (!(rdActive && pix == 200)) begin
            compared++;
            mismatched++;
            $display("FAIL midpass_setup: pass never reached pixel 200");
        end
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

        pw = 50; pr = 70;
        for (int i = 0; i < 8000; i++) begin
            if (i % 500 == 0) begin
                pw = $urandom_range(5, 100);
                pr = $urandom_range(20, 100);
            end
            cycle($urandom_range(0, 2999) != 0, $urandom_range(0, 2499) == 0,
                  $urandom_range(0, 99) < pw, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 99) < pr);
        end

        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("wrQ_drained", wrQ.size(), 0);
        check("rdQ_drained", rdQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
